// File: rtl/irr_if.sv
// Request/acknowledge bundle between the PIC control logic and the interrupt request register.
interface irr_if;
    logic       LTIM;
    logic       ir0;
    logic       ir1;
    logic       ir2;
    logic       ir3;
    logic       ir4;
    logic       ir5;
    logic       ir6;
    logic       ir7;
    logic [7:0] imr;
    logic       freeze;
    logic [7:0] clr;
    logic [7:0] irr;
    logic       int_req;
    logic [2:0] irq_id;
    logic       irq_valid;

    // Control side: drives requests, mask, freeze and clears; observes the pending state.
    modport master (
        output LTIM, ir0, ir1, ir2, ir3, ir4, ir5, ir6, ir7, imr, freeze, clr,
        input  irr, int_req, irq_id, irq_valid
    );

    // Register side: the irr block itself.
    modport slave (
        input  LTIM, ir0, ir1, ir2, ir3, ir4, ir5, ir6, ir7, imr, freeze, clr,
        output irr, int_req, irq_id, irq_valid
    );
endinterface

// File: rtl/irr.sv
// Interrupt request register: synchronizes eight request lines, latches them in edge or
// level mode, and presents the masked request and fixed-priority index.
module irr (
    input logic   clk,
    input logic   reset,
    irr_if.slave  bus
);

    logic [7:0] ir_vec;
    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] set_vec;
    logic [7:0] masked;
    logic [2:0] id;

    assign ir_vec = {bus.ir7, bus.ir6, bus.ir5, bus.ir4, bus.ir3, bus.ir2, bus.ir1, bus.ir0};

    // Next-state: synchronizer, edge history (frozen during INTA) and request latch.
    always_comb begin
        s1_d    = ir_vec;
        s2_d    = s1_q;
        prev_d  = bus.freeze ? prev_q : s2_q;
        set_vec = s2_q & ~prev_q & {8{~bus.freeze}};
        irr_d   = irr_q;
        if (bus.LTIM) begin
            irr_d = bus.freeze ? (irr_q & ~bus.clr) : (s2_q & ~bus.clr);
        end else begin
            // A new edge wins over a same-cycle clear of that bit.
            irr_d = set_vec | (irr_q & ~bus.clr);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            prev_q <= 8'h00;
            irr_q  <= 8'h00;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            irr_q  <= irr_d;
        end
    end

    // Fixed priority: lowest-numbered unmasked pending bit; scan downward so bit 0 wins.
    always_comb begin
        masked = irr_q & ~bus.imr;
        id     = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (masked[i]) begin
                id = 3'(i);
            end
        end
    end

    assign bus.irr       = irr_q;
    assign bus.int_req   = |masked;
    assign bus.irq_valid = |masked;
    assign bus.irq_id    = id;

endmodule

// File: tb/tb_irr.sv
// Directed-vector bench for the interrupt request register.
module tb_irr;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    irr_if bus ();

    irr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary (got running, need finished)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end
    endtask

    task automatic set_ir(input logic [7:0] v);
        {bus.ir7, bus.ir6, bus.ir5, bus.ir4, bus.ir3, bus.ir2, bus.ir1, bus.ir0} = v;
    endtask

    // Advance n rising edges, landing on a falling edge; settle a little before sampling.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b0;
        bus.LTIM   = 1'b0;
        bus.imr    = 8'h00;
        bus.freeze = 1'b0;
        bus.clr    = 8'h00;
        set_ir(8'hFF);
        @(negedge clk);

        // Reset with all lines high
        step(2);
        check("rst_irr", bus.irr, 8'h00);
        check("rst_int_req", {7'd0, bus.int_req}, 8'h00);
        check("rst_irq_id", {5'd0, bus.irq_id}, 8'h00);
        check("rst_irq_valid", {7'd0, bus.irq_valid}, 8'h00);
        reset = 1'b1;
        step(2);
        check("rel_lat2", bus.irr, 8'h00);
        step(1);
        check("rel_lat3", bus.irr, 8'hFF);
        check("rel_int_req", {7'd0, bus.int_req}, 8'h01);
        check("rel_irq_id", {5'd0, bus.irq_id}, 8'h00);
        set_ir(8'h00);
        bus.clr = 8'hFF;
        step(1);
        bus.clr = 8'h00;
        check("clr_all", bus.irr, 8'h00);
        step(3);
        check("clr_all_hold", bus.irr, 8'h00);

        // Edge latch and clear on ir3
        set_ir(8'h08);
        step(1);
        set_ir(8'h00);
        step(1);
        check("edge_lat2", bus.irr, 8'h00);
        step(1);
        check("edge_lat3", bus.irr, 8'h08);
        check("edge_id", {5'd0, bus.irq_id}, 8'h03);
        step(3);
        check("edge_persist", bus.irr, 8'h08);
        bus.clr = 8'h08;
        step(1);
        bus.clr = 8'h00;
        check("edge_clr", bus.irr, 8'h00);
        step(2);
        check("edge_clr_hold", bus.irr, 8'h00);

        // Level mode on ir0
        bus.LTIM = 1'b1;
        set_ir(8'h01);
        step(2);
        check("lvl_lat2", bus.irr, 8'h00);
        step(1);
        check("lvl_lat3", bus.irr, 8'h01);
        bus.clr = 8'h01;
        step(1);
        bus.clr = 8'h00;
        check("lvl_clr", bus.irr, 8'h00);
        step(1);
        check("lvl_reset", bus.irr, 8'h01);
        set_ir(8'h00);
        step(2);
        check("lvl_fall2", bus.irr, 8'h01);
        step(1);
        check("lvl_fall3", bus.irr, 8'h00);

        // Priority and mask
        set_ir(8'h24);
        step(3);
        check("pri_irr", bus.irr, 8'h24);
        check("pri_id_2", {5'd0, bus.irq_id}, 8'h02);
        check("pri_req", {7'd0, bus.int_req}, 8'h01);
        bus.imr = 8'h04;
        #1;
        check("pri_id_5", {5'd0, bus.irq_id}, 8'h05);
        check("pri_valid_5", {7'd0, bus.irq_valid}, 8'h01);
        bus.imr = 8'h24;
        #1;
        check("mask_req", {7'd0, bus.int_req}, 8'h00);
        check("mask_valid", {7'd0, bus.irq_valid}, 8'h00);
        check("mask_id", {5'd0, bus.irq_id}, 8'h00);
        check("mask_irr", bus.irr, 8'h24);
        bus.imr = 8'h00;

        // Level to edge: ir4 held high, no spurious edge after clearing
        set_ir(8'h10);
        step(3);
        check("l2e_lvl", bus.irr, 8'h10);
        bus.LTIM = 1'b0;
        step(1);
        check("l2e_retain", bus.irr, 8'h10);
        bus.clr = 8'h10;
        step(1);
        bus.clr = 8'h00;
        step(3);
        check("l2e_no_edge", bus.irr, 8'h00);
        set_ir(8'h00);
        step(3);

        // Freeze: edge held off until release
        bus.freeze = 1'b1;
        set_ir(8'h40);
        step(4);
        check("frz_block", bus.irr, 8'h00);
        bus.freeze = 1'b0;
        step(1);
        check("frz_release", bus.irr, 8'h40);
        bus.clr = 8'h40;
        step(1);
        bus.clr = 8'h00;
        set_ir(8'h00);
        step(3);
        // Freeze: edge lost when the line falls before release
        bus.freeze = 1'b1;
        set_ir(8'h40);
        step(3);
        set_ir(8'h00);
        step(3);
        bus.freeze = 1'b0;
        step(2);
        check("frz_lost", bus.irr, 8'h00);

        // Set/clear collision on ir1
        set_ir(8'h02);
        step(2);
        bus.clr = 8'h02;
        step(1);
        bus.clr = 8'h00;
        check("collide_set_wins", bus.irr, 8'h02);
        check("collide_id", {5'd0, bus.irq_id}, 8'h01);

        // Mid-operation reset, line held high through release
        reset = 1'b0;
        step(1);
        check("midrst_irr", bus.irr, 8'h00);
        check("midrst_req", {7'd0, bus.int_req}, 8'h00);
        reset = 1'b1;
        step(2);
        check("midrst_lat2", bus.irr, 8'h00);
        step(1);
        check("midrst_edge", bus.irr, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
